// File: rtl/irq_ctrl.sv
// irq_ctrl: interrupt aggregation device on the system bridge.
//   Latches per-source device IRQs (edge or level mode), masks them with
//   ENABLE, and presents a prioritised vector plus a summary IRQ to CP0.
// Ports:
//   clk    - system clock, all state on rising edge
//   reset  - asynchronous active-low reset
//   Addr   - word address [31:2]; Addr[4:2] selects the register
//   WE     - write strobe (device already selected)
//   Din    - write data
//   Dout   - read data, combinational from Addr[4:2]
//   IrqIn  - device IRQ levels (same clock domain)
//   HWInt  - pending & enable, to CP0 Cause.IP
//   IRQ    - OR of HWInt
// Register map (Addr[4:2]): 0 ENABLE, 1 PENDING (W1C), 2 MODE (1=edge),
//   3 VECTOR {valid,28'b0,idx}, 4 COUNT (only with IRQ_CNT_EN), others 0.
// Optional feature: define IRQ_CNT_EN for per-source 8-bit saturating
//   rise counters readable through COUNT (sources 0-3, byte per source).
module irq_ctrl #(
  parameter int unsigned N_SRC = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:2]      Addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] IrqIn,
  output logic [N_SRC-1:0] HWInt,
  output logic             IRQ
);

  logic [N_SRC-1:0] enable_q, enable_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] prev_q, prev_d;

  logic [2:0]       sel;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic             vec_valid;
  logic [2:0]       vec_idx;
  logic             vec_found;

  logic unused_bits;
  assign unused_bits = ^{Addr[31:5], Din[31:N_SRC]};

  assign sel  = Addr[4:2];
  assign rise = IrqIn & ~prev_q;
  assign clr  = (WE && sel == 3'd1) ? Din[N_SRC-1:0] : '0;

`ifdef IRQ_CNT_EN
  logic [N_SRC-1:0][7:0] cnt_q, cnt_d;

  // A level source's 0->1 transition is the same event as rise, so one
  // increment condition serves both modes. A COUNT write wins over a rise.
  always_comb begin
    cnt_d = cnt_q;
    if (WE && sel == 3'd4) begin
      cnt_d = '0;
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (rise[i] && cnt_q[i] != 8'hFF) cnt_d[i] = cnt_q[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  always_comb begin
    enable_d = (WE && sel == 3'd0) ? Din[N_SRC-1:0] : enable_q;
    mode_d   = (WE && sel == 3'd2) ? Din[N_SRC-1:0] : mode_q;
    prev_d   = IrqIn;
    // Uses the registered mode so a MODE write never disturbs PENDING in
    // the write cycle; in edge mode a set beats a same-cycle clear.
    for (int unsigned i = 0; i < N_SRC; i++) begin
      pending_d[i] = mode_q[i] ? (rise[i] | (pending_q[i] & ~clr[i]))
                               : IrqIn[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q  <= '0;
      pending_q <= '0;
      mode_q    <= '0;
      prev_q    <= '0;
    end else begin
      enable_q  <= enable_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      prev_q    <= prev_d;
    end
  end

  assign HWInt = pending_q & enable_q;
  assign IRQ   = |HWInt;

  always_comb begin
    vec_valid = |HWInt;
    vec_idx   = '0;
    vec_found = 1'b0;
    for (int unsigned i = 0; i < N_SRC; i++) begin
      if (HWInt[i] && !vec_found) begin
        vec_idx   = 3'(i);
        vec_found = 1'b1;
      end
    end
  end

  always_comb begin
    Dout = '0;
    unique case (sel)
      3'd0: Dout[N_SRC-1:0] = enable_q;
      3'd1: Dout[N_SRC-1:0] = pending_q;
      3'd2: Dout[N_SRC-1:0] = mode_q;
      3'd3: Dout = {vec_valid, 28'b0, vec_idx};
`ifdef IRQ_CNT_EN
      3'd4: begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (i < N_SRC) Dout[8*i +: 8] = cnt_q[i];
        end
      end
`endif
      default: Dout = '0;
    endcase
  end

endmodule
